// File: rtl/verdict_tally_pkg.sv
// Shared definitions for the verdict tally block: verdict codes (common with
// the upstream evaluator) and the tally FSM state encoding.
package verdict_tally_pkg;

    // Verdict codes. Bit 1 set means a completed verdict.
    localparam logic [1:0] VERD_NONE = 2'b00;
    localparam logic [1:0] VERD_ADV  = 2'b01;
    localparam logic [1:0] VERD_REJ  = 2'b10;
    localparam logic [1:0] VERD_APP  = 2'b11;

    // Tally FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        SHOW  = 2'd2
    } state_t;

    // True for the two completed-verdict codes (rejected / approved).
    function automatic logic is_final(input logic [1:0] v);
        return v[1];
    endfunction

endpackage

// File: rtl/verdict_tally_sat_counter.sv
// Saturating up-counter with synchronous clear. hit_max flags an increment
// request that arrives while the counter already holds its maximum value.
module sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             hit_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise increment unless already at maximum.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt     = cnt_q;
    assign hit_max = inc && !clr && (cnt_q == CNT_MAX);

endmodule

// File: rtl/verdict_tally.sv
// Verdict tally: counts approved/rejected verdicts from the evaluator,
// holds the last verdict on a display output for HOLD_CYCLES cycles and
// flags verdicts that arrive without a preceding "advancing" code.
//
// Handshake: there is none. verdict is sampled every cycle; a completed
// verdict is an edge (code 1x differing from the previous cycle's code), so
// a held verdict is counted once. All outputs are registered and change on
// the clock edge that samples the causing input.
module verdict_tally
    import verdict_tally_pkg::*;
#(
    parameter int CNT_W       = 8,
    parameter int HOLD_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       verdict,
    input  logic             clear,
    output logic [CNT_W-1:0] approved_cnt,
    output logic [CNT_W-1:0] rejected_cnt,
    output logic             sat,
    output logic             protocol_err,
    output logic             busy,
    output logic             result_pulse,
    output logic [1:0]       disp_verdict,
    output state_t           dbg_state_o
);

    localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

    state_t        state_q;
    logic [1:0]    verdict_q;
    logic [1:0]    last_q;
    logic [TW-1:0] timer_q;
    logic          sat_q;
    logic          perr_q;
    logic          busy_q;
    logic          pulse_q;
    logic [1:0]    disp_q;

    logic evt;
    logic accept;
    logic inc_app;
    logic inc_rej;
    logic hit_app;
    logic hit_rej;

    // A verdict edge; clear in the same cycle discards it.
    assign evt     = is_final(verdict) && (verdict != verdict_q);
    assign accept  = evt && !clear;
    assign inc_app = accept && (verdict == VERD_APP);
    assign inc_rej = accept && (verdict == VERD_REJ);

    sat_counter #(.CNT_W(CNT_W)) u_app_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .inc     (inc_app),
        .cnt     (approved_cnt),
        .hit_max (hit_app)
    );

    sat_counter #(.CNT_W(CNT_W)) u_rej_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .inc     (inc_rej),
        .cnt     (rejected_cnt),
        .hit_max (hit_rej)
    );

    // Tally FSM with its registered outputs; busy/disp are rewritten every
    // cycle so they always reflect the state being entered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            verdict_q <= VERD_NONE;
            last_q    <= VERD_NONE;
            timer_q   <= '0;
            sat_q     <= 1'b0;
            perr_q    <= 1'b0;
            busy_q    <= 1'b0;
            pulse_q   <= 1'b0;
            disp_q    <= VERD_NONE;
        end else begin
            verdict_q <= verdict;
            pulse_q   <= 1'b0;
            busy_q    <= 1'b0;
            disp_q    <= VERD_NONE;
            if (clear) begin
                state_q <= IDLE;
                last_q  <= VERD_NONE;
                timer_q <= '0;
                sat_q   <= 1'b0;
                perr_q  <= 1'b0;
            end else begin
                if (hit_app || hit_rej) begin
                    sat_q <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (verdict == VERD_ADV) begin
                            state_q <= ARMED;
                            busy_q  <= 1'b1;
                        end else if (evt) begin
                            // Verdict without an advancing code: still counted.
                            perr_q  <= 1'b1;
                            state_q <= SHOW;
                            timer_q <= HOLD_LAST;
                            last_q  <= verdict;
                            pulse_q <= 1'b1;
                            disp_q  <= verdict;
                        end
                    end
                    ARMED: begin
                        if (evt) begin
                            state_q <= SHOW;
                            timer_q <= HOLD_LAST;
                            last_q  <= verdict;
                            pulse_q <= 1'b1;
                            disp_q  <= verdict;
                        end else if (verdict == VERD_NONE) begin
                            // Candidate abandoned; nothing counted.
                            state_q <= IDLE;
                        end else begin
                            busy_q <= 1'b1;
                        end
                    end
                    SHOW: begin
                        if (verdict == VERD_ADV) begin
                            // New candidate: blank display, keep last_q.
                            state_q <= ARMED;
                            busy_q  <= 1'b1;
                        end else if (evt) begin
                            timer_q <= HOLD_LAST;
                            last_q  <= verdict;
                            pulse_q <= 1'b1;
                            disp_q  <= verdict;
                        end else if (timer_q == '0) begin
                            state_q <= IDLE;
                        end else begin
                            timer_q <= timer_q - 1'b1;
                            disp_q  <= last_q;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign sat          = sat_q;
    assign protocol_err = perr_q;
    assign busy         = busy_q;
    assign result_pulse = pulse_q;
    assign disp_verdict = disp_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_verdict_tally.sv
// Directed bench for verdict_tally. A default instance (CNT_W=8) and a
// narrow instance (CNT_W=2) share the same stimulus; the narrow one is
// checked for saturation. Inputs change on the falling edge, outputs are
// sampled 1ns after the rising edge.
module tb_verdict_tally;
    import verdict_tally_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic [1:0] verdict;
    logic clear;

    always #5 clk = ~clk;

    logic [7:0] a1, r1;
    logic       sat1, perr1, busy1, pulse1;
    logic [1:0] disp1;
    state_t     st1;

    logic [1:0] a2, r2;
    logic       sat2, perr2, busy2, pulse2;
    logic [1:0] disp2;
    state_t     st2;

    verdict_tally #(.CNT_W(8), .HOLD_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .verdict      (verdict),
        .clear        (clear),
        .approved_cnt (a1),
        .rejected_cnt (r1),
        .sat          (sat1),
        .protocol_err (perr1),
        .busy         (busy1),
        .result_pulse (pulse1),
        .disp_verdict (disp1),
        .dbg_state_o  (st1)
    );

    verdict_tally #(.CNT_W(2), .HOLD_CYCLES(4)) dut_narrow (
        .clk          (clk),
        .rst          (rst),
        .verdict      (verdict),
        .clear        (clear),
        .approved_cnt (a2),
        .rejected_cnt (r2),
        .sat          (sat2),
        .protocol_err (perr2),
        .busy         (busy2),
        .result_pulse (pulse2),
        .disp_verdict (disp2),
        .dbg_state_o  (st2)
    );

    // ---------------- checking ----------------
    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [1:0] v, input logic c, input logic r);
        @(negedge clk);
        verdict = v;
        clear   = c;
        rst     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_app"},   32'(a1),     32'd0);
        check_eq({tag, "_rej"},   32'(r1),     32'd0);
        check_eq({tag, "_sat"},   32'(sat1),   32'd0);
        check_eq({tag, "_perr"},  32'(perr1),  32'd0);
        check_eq({tag, "_busy"},  32'(busy1),  32'd0);
        check_eq({tag, "_pulse"}, 32'(pulse1), 32'd0);
        check_eq({tag, "_disp"},  32'(disp1),  32'd0);
        check_eq({tag, "_state"}, 32'(st1),    32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst     = 1'b1;
        verdict = 2'b00;
        clear   = 1'b0;
        step(2'b00, 1'b0, 1'b1);
        step(2'b00, 1'b0, 1'b1);
        check_all_zero("reset");
        check_eq("reset_sat2", 32'(sat2), 32'd0);

        // Basic approval: 00,01,01,11 (held), then display times out.
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        check_eq("t1_busy_armed", 32'(busy1), 32'd1);
        step(2'b01, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        check_eq("t1_app", 32'(a1), 32'd1);
        check_eq("t1_pulse", 32'(pulse1), 32'd1);
        check_eq("t1_disp0", 32'(disp1), 32'd3);
        check_eq("t1_busy_show", 32'(busy1), 32'd0);
        step(2'b11, 1'b0, 1'b0);
        check_eq("t1_pulse_once", 32'(pulse1), 32'd0);
        check_eq("t1_held_once", 32'(a1), 32'd1);
        check_eq("t1_disp1", 32'(disp1), 32'd3);
        step(2'b00, 1'b0, 1'b0);
        check_eq("t1_disp2", 32'(disp1), 32'd3);
        step(2'b00, 1'b0, 1'b0);
        check_eq("t1_disp3", 32'(disp1), 32'd3);
        step(2'b00, 1'b0, 1'b0);
        check_eq("t1_disp_off", 32'(disp1), 32'd0);
        check_eq("t1_idle", 32'(st1), 32'd0);
        check_eq("t1_perr", 32'(perr1), 32'd0);

        // Three rejections, each preceded by 01.
        for (int k = 1; k <= 3; k++) begin
            step(2'b01, 1'b0, 1'b0);
            check_eq("t2_busy", 32'(busy1), 32'd1);
            step(2'b10, 1'b0, 1'b0);
            check_eq("t2_rej", 32'(r1), 32'(k));
            check_eq("t2_pulse", 32'(pulse1), 32'd1);
            step(2'b00, 1'b0, 1'b0);
        end
        check_eq("t2_app_kept", 32'(a1), 32'd1);
        check_eq("t2_perr", 32'(perr1), 32'd0);
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0, 1'b0);

        // Verdict with no preceding 01: flagged but still counted; clear undoes it.
        step(2'b00, 1'b1, 1'b0);
        check_all_zero("t3_clear");
        step(2'b11, 1'b0, 1'b0);
        check_eq("t3_perr", 32'(perr1), 32'd1);
        check_eq("t3_app", 32'(a1), 32'd1);
        check_eq("t3_pulse", 32'(pulse1), 32'd1);
        for (int k = 0; k < 5; k++) step(2'b00, 1'b0, 1'b0);
        check_eq("t3_perr_sticky", 32'(perr1), 32'd1);
        step(2'b00, 1'b1, 1'b0);
        check_eq("t3_perr_clr", 32'(perr1), 32'd0);
        check_eq("t3_app_clr", 32'(a1), 32'd0);

        // Saturation on the narrow instance: five approvals.
        for (int k = 1; k <= 5; k++) begin
            step(2'b01, 1'b0, 1'b0);
            step(2'b11, 1'b0, 1'b0);
            check_eq("t4_app_wide", 32'(a1), 32'(k));
            check_eq("t4_app_narrow", 32'(a2), (k >= 3) ? 32'd3 : 32'(k));
            check_eq("t4_sat_narrow", 32'(sat2), (k >= 4) ? 32'd1 : 32'd0);
            check_eq("t4_rej_narrow", 32'(r2), 32'd0);
            check_eq("t4_sat_wide", 32'(sat1), 32'd0);
        end

        // Clear coincident with a 01->10 transition drops the verdict.
        step(2'b00, 1'b1, 1'b0);
        check_eq("t5_sat_clr", 32'(sat2), 32'd0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b10, 1'b1, 1'b0);
        check_eq("t5_rej", 32'(r1), 32'd0);
        check_eq("t5_pulse", 32'(pulse1), 32'd0);
        check_eq("t5_state", 32'(st1), 32'd0);
        check_eq("t5_disp", 32'(disp1), 32'd0);
        step(2'b10, 1'b0, 1'b0);
        check_eq("t5_held_no_evt", 32'(r1), 32'd0);
        check_eq("t5_held_pulse", 32'(pulse1), 32'd0);
        check_eq("t5_held_perr", 32'(perr1), 32'd0);

        // New candidate interrupts SHOW, then a rejection; then reset mid-SHOW.
        step(2'b00, 1'b0, 1'b0);
        step(2'b01, 1'b0, 1'b0);
        step(2'b11, 1'b0, 1'b0);
        check_eq("t6_disp_app", 32'(disp1), 32'd3);
        step(2'b01, 1'b0, 1'b0);
        check_eq("t6_disp_drop", 32'(disp1), 32'd0);
        check_eq("t6_busy", 32'(busy1), 32'd1);
        check_eq("t6_state", 32'(st1), 32'd1);
        step(2'b10, 1'b0, 1'b0);
        check_eq("t6_disp_rej", 32'(disp1), 32'd2);
        check_eq("t6_rej", 32'(r1), 32'd1);
        check_eq("t6_app", 32'(a1), 32'd1);
        step(2'b10, 1'b0, 1'b1);
        check_all_zero("t6_rst");
        // Reset also cleared the sampled verdict, so a held 10 now looks new.
        step(2'b10, 1'b0, 1'b0);
        check_eq("t6_post_rst_rej", 32'(r1), 32'd1);
        check_eq("t6_post_rst_perr", 32'(perr1), 32'd1);

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
